temporizador_bcd: RTL

//  Countdown timer feeding the HORAT/MINT/SEGT/ALARMA inputs of the VGA display stage.

---
 rtl/temporizador_bcd.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/temporizador_bcd.sv
// -----------------------------------------------------------------------------
// temporizador_bcd
//   Countdown timer for the VGA display stage. It holds an HH:MM:SS value as
//   packed BCD and decrements it once per second while running. When the count
//   reaches 00:00:00 it raises a latched alarm. An internal prescaler derives
//   the one-second tick from CLK. All outputs are registered, so they stay
//   stable between ticks.
//
// Parameters
//   CLK_HZ     CLK cycles per second (>= 2). The prescaler wraps at CLK_HZ-1.
//
// Ports
//   CLK        in   1  system clock
//   RST        in   1  asynchronous active-low reset
//   LOAD       in   1  pulse: load HORA_IN/MIN_IN/SEG_IN (IDLE/PAUSE only)
//   HORA_IN    in   8  BCD hours   00-23
//   MIN_IN     in   8  BCD minutes 00-59
//   SEG_IN     in   8  BCD seconds 00-59
//   START      in   1  pulse: begin/resume counting
//   STOP       in   1  pulse: pause counting
//   ALARM_ACK  in   1  pulse: clear alarm
//   HORAT      out  8  BCD hours remaining
//   MINT       out  8  BCD minutes remaining
//   SEGT       out  8  BCD seconds remaining
//   ALARMA     out  1  high from expiry until acknowledged
//   RUNNING    out  1  high while counting
//   LOAD_ERR   out  1  one-cycle pulse on a rejected LOAD
// -----------------------------------------------------------------------------
module temporizador_bcd #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [7:0] HORA_IN,
  input  logic [7:0] MIN_IN,
  input  logic [7:0] SEG_IN,
  input  logic       START,
  input  logic       STOP,
  input  logic       ALARM_ACK,
  output logic [7:0] HORAT,
  output logic [7:0] MINT,
  output logic [7:0] SEGT,
  output logic       ALARMA,
  output logic       RUNNING,
  output logic       LOAD_ERR
);

  localparam int              PW   = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   TERM = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [23:0]   cnt, cnt_n;        // {hours, minutes, seconds}
  logic [PW-1:0] presc, presc_n;
  logic          load_err_n;
  logic          tick;
  logic          cnt_zero;
  logic [23:0]   cnt_dec;
  logic          load_ok;

  // Decrements a 00-59 BCD field. Bit 8 flags a borrow (00 -> 59).
  function automatic logic [8:0] dec_60(input logic [7:0] v);
    logic [3:0] tens, ones;
    logic       borrow;
    tens   = v[7:4];
    ones   = v[3:0];
    borrow = 1'b0;
    if (ones != 4'd0) begin
      ones = ones - 4'd1;
    end else begin
      ones = 4'd9;
      if (tens != 4'd0) begin
        tens = tens - 4'd1;
      end else begin
        tens   = 4'd5;
        borrow = 1'b1;
      end
    end
    return {borrow, tens, ones};
  endfunction

  // Decrements the hours field. It is only reached with a non-zero count, so
  // hours are never decremented below 00.
  function automatic logic [7:0] dec_hr(input logic [7:0] v);
    logic [3:0] tens, ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones != 4'd0) begin
      ones = ones - 4'd1;
    end else begin
      ones = 4'd9;
      tens = tens - 4'd1;
    end
    return {tens, ones};
  endfunction

  // Subtracts one second from HH:MM:SS, carrying the borrow from seconds
  // through minutes into hours.
  function automatic logic [23:0] dec_time(input logic [23:0] t);
    logic [8:0] s_r, m_r;
    logic [7:0] h;
    logic [7:0] m;
    h   = t[23:16];
    m   = t[15:8];
    s_r = dec_60(t[7:0]);
    m_r = s_r[8] ? dec_60(m) : {1'b0, m};
    if (m_r[8]) h = dec_hr(h);
    return {h, m_r[7:0], s_r[7:0]};
  endfunction

  function automatic logic valid_bcd(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s);
    return (h[3:0] <= 4'd9) && (h <= 8'h23) &&
           (m[3:0] <= 4'd9) && (m[7:4] <= 4'd5) &&
           (s[3:0] <= 4'd9) && (s[7:4] <= 4'd5);
  endfunction

  assign tick     = (presc == TERM);
  assign cnt_zero = (cnt == 24'h00_00_00);
  assign cnt_dec  = dec_time(cnt);
  assign load_ok  = valid_bcd(HORA_IN, MIN_IN, SEG_IN);

  // NOTE: every signal driven here gets a default before the case. Otherwise
  // an incomplete branch would infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    presc_n    = presc;
    load_err_n = 1'b0;

    case (state)
      S_IDLE, S_PAUSE: begin
        // STOP outranks START and LOAD, but there is nothing to stop here.
        if (!STOP) begin
          if (START) begin
            if (!cnt_zero) begin
              state_n = S_RUN;
              // A fresh run starts a full second. A resume keeps the
              // partial second that was already counted.
              if (state == S_IDLE) presc_n = '0;
            end
          end else if (LOAD) begin
            if (load_ok) cnt_n      = {HORA_IN, MIN_IN, SEG_IN};
            else         load_err_n = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (STOP) begin
          // Pause: the prescaler holds and any tick in this cycle is dropped.
          state_n = S_PAUSE;
        end else begin
          presc_n = tick ? '0 : presc + 1'b1;
          if (tick && !cnt_zero) begin
            cnt_n = cnt_dec;
            if (cnt_dec == 24'h00_00_00) state_n = S_ALARM;
          end
        end
      end

      S_ALARM: begin
        if (ALARM_ACK) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      presc    <= '0;
      ALARMA   <= 1'b0;
      RUNNING  <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      presc    <= presc_n;
      // Flags are registered from the next state, so they change on the same
      // edge as the state and the count.
      ALARMA   <= (state_n == S_ALARM);
      RUNNING  <= (state_n == S_RUN);
      LOAD_ERR <= load_err_n;
    end
  end

  assign {HORAT, MINT, SEGT} = cnt;

endmodule
